// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM states, default geometry and
// the bit positions of the condition flags inside a pushed flags word.
package mem_stage_pkg;

    localparam int MEM_ADDR_WIDTH = 11;
    localparam int MEM_DATA_WIDTH = 16;

    localparam int ZF = 0;
    localparam int CF = 1;
    localparam int NF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Single-port data/stack RAM with one write enable and a registered read port
// (read-first: a simultaneous write returns the old word).
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: loads, stores, flag push/pop and two-word PC push/pop
// against the data/stack RAM, producing registered MEM/WB fields.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] Data,
    input  logic [31:0]             Address,
    input  logic [2:0]              WB_Address,
    input  logic                    MR,
    input  logic                    MW,
    input  logic                    WB,
    input  logic                    JWSP,
    input  logic                    Stack_PC,
    input  logic                    Stack_Flags,
    input  logic [2:0]              Final_Flags,
    output logic                    Stall,
    output logic                    SP_Extra,
    output logic                    SP_Extra_Inc,
    output logic                    WB_Out,
    output logic [2:0]              WB_Address_Out,
    output logic [DATA_WIDTH-1:0]   WB_Data,
    output logic                    Flags_Load,
    output logic [2:0]              Flags_Out,
    output logic                    PC_Load,
    output logic [2*DATA_WIDTH-1:0] PC_Out
);

    mem_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic is_write;
    logic is_read;
    logic flags_op;
    logic two_word;
    logic unused_addr_bits;

    logic                    wb_q;
    logic [2:0]              wb_addr_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic                    wb_from_mem_q;
    logic                    flags_pop_q;
    logic [2:0]              flags_hold_q;
    logic [DATA_WIDTH-1:0]   pc_lo_q;
    logic                    pc_pop_q;
    logic                    pc_load_q;
    logic [2*DATA_WIDTH-1:0] pc_hold_q;

    // A write always wins over a read; Stack_PC takes priority over Stack_Flags.
    assign addr_a           = Address[ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^Address[31:ADDR_WIDTH];
    assign is_write         = MW;
    assign is_read          = MR & ~MW;
    assign flags_op         = Stack_Flags & ~Stack_PC;
    assign two_word         = Stack_PC & (MR | MW);

    data_memory #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // PC pushes store the high word at A and the low word at A-1, so a pop
    // reads the low word at A and the high word at A+1.
    always_comb begin
        state_d      = state_q;
        Stall        = 1'b0;
        SP_Extra     = 1'b0;
        SP_Extra_Inc = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr_a;
        mem_wdata    = Data[DATA_WIDTH-1:0];

        case (state_q)
            IDLE: begin
                mem_we = is_write;
                if (two_word) begin
                    Stall     = 1'b1;
                    state_d   = SECOND;
                    mem_wdata = Data[2*DATA_WIDTH-1:DATA_WIDTH];
                end else if (flags_op) begin
                    mem_wdata = {{(DATA_WIDTH-3){1'b0}}, Final_Flags};
                end
            end
            SECOND: begin
                state_d      = IDLE;
                SP_Extra     = 1'b1;
                SP_Extra_Inc = is_read;
                mem_we       = is_write;
                mem_addr     = is_write ? (addr_a - ADDR_WIDTH'(1)) : (addr_a + ADDR_WIDTH'(1));
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            state_d      = IDLE;
            Stall        = 1'b0;
            SP_Extra     = 1'b0;
            SP_Extra_Inc = 1'b0;
            mem_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read results come straight from the RAM's output register; the *_q
    // select bits steer them onto the outputs and the hold registers keep
    // popped values stable once the select drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q          <= 1'b0;
            wb_addr_q     <= 3'b000;
            wb_data_q     <= '0;
            wb_from_mem_q <= 1'b0;
            flags_pop_q   <= 1'b0;
            flags_hold_q  <= 3'b000;
            pc_lo_q       <= '0;
            pc_pop_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_hold_q     <= '0;
        end else begin
            flags_hold_q  <= Flags_Out;
            pc_hold_q     <= PC_Out;
            wb_from_mem_q <= 1'b0;
            flags_pop_q   <= 1'b0;
            pc_pop_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            wb_q          <= WB;
            wb_addr_q     <= WB_Address;
            wb_data_q     <= Data[DATA_WIDTH-1:0];

            if (state_q == SECOND) begin
                if (is_read) begin
                    pc_lo_q   <= mem_rdata;
                    pc_pop_q  <= 1'b1;
                    pc_load_q <= JWSP;
                end
            end else if (two_word) begin
                wb_q <= 1'b0;
            end else if (is_read && flags_op) begin
                flags_pop_q <= 1'b1;
            end else if (is_read) begin
                wb_from_mem_q <= 1'b1;
            end
        end
    end

    assign WB_Out         = wb_q;
    assign WB_Address_Out = wb_addr_q;
    assign WB_Data        = wb_from_mem_q ? mem_rdata : wb_data_q;
    assign Flags_Load     = flags_pop_q;
    assign Flags_Out      = flags_pop_q ? mem_rdata[NF:ZF] : flags_hold_q;
    assign PC_Load        = pc_load_q;
    assign PC_Out         = pc_pop_q ? {mem_rdata, pc_lo_q} : pc_hold_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by random
// operations, all checked against a word-array model of the stack memory.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Data;
    logic [31:0] Address;
    logic [2:0]  WB_Address;
    logic        MR, MW, WB, JWSP, Stack_PC, Stack_Flags;
    logic [2:0]  Final_Flags;
    logic        Stall, SP_Extra, SP_Extra_Inc, WB_Out;
    logic [2:0]  WB_Address_Out;
    logic [15:0] WB_Data;
    logic        Flags_Load;
    logic [2:0]  Flags_Out;
    logic        PC_Load;
    logic [31:0] PC_Out;

    int totalChecks  = 0;
    int passedChecks = 0;
    int failedChecks = 0;

    logic [15:0] refMem [2048];

    memory_stage dut (
        .clk           (clk),
        .rst           (rst),
        .Data          (Data),
        .Address       (Address),
        .WB_Address    (WB_Address),
        .MR            (MR),
        .MW            (MW),
        .WB            (WB),
        .JWSP          (JWSP),
        .Stack_PC      (Stack_PC),
        .Stack_Flags   (Stack_Flags),
        .Final_Flags   (Final_Flags),
        .Stall         (Stall),
        .SP_Extra      (SP_Extra),
        .SP_Extra_Inc  (SP_Extra_Inc),
        .WB_Out        (WB_Out),
        .WB_Address_Out(WB_Address_Out),
        .WB_Data       (WB_Data),
        .Flags_Load    (Flags_Load),
        .Flags_Out     (Flags_Out),
        .PC_Load       (PC_Load),
        .PC_Out        (PC_Out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) passedChecks++;
        else begin
            failedChecks++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic mw, input logic spc, input logic sfl,
                                 input logic jwsp, input logic wb, input logic [2:0] wba,
                                 input logic [31:0] data, input logic [31:0] addr, input logic [2:0] ff);
        MR          = mr;
        MW          = mw;
        Stack_PC    = spc;
        Stack_Flags = sfl;
        JWSP        = jwsp;
        WB          = wb;
        WB_Address  = wba;
        Data        = data;
        Address     = addr;
        Final_Flags = ff;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".wb_out"}, 32'(WB_Out), 32'd0);
        checkOutput({tag, ".wb_addr"}, 32'(WB_Address_Out), 32'd0);
        checkOutput({tag, ".wb_data"}, 32'(WB_Data), 32'd0);
        checkOutput({tag, ".pc_load"}, 32'(PC_Load), 32'd0);
        checkOutput({tag, ".pc_out"}, PC_Out, 32'd0);
        checkOutput({tag, ".flags_load"}, 32'(Flags_Load), 32'd0);
        checkOutput({tag, ".flags_out"}, 32'(Flags_Out), 32'd0);
        checkOutput({tag, ".sp_extra"}, 32'(SP_Extra), 32'd0);
        checkOutput({tag, ".stall"}, 32'(Stall), 32'd0);
    endtask

    // Runs one EX/MEM operation to completion, holding inputs through the stall,
    // and compares every visible effect against the memory model.
    task automatic runOp(input string tag, input logic mr, input logic mw, input logic spc,
                         input logic sfl, input logic jwsp, input logic wb, input logic [2:0] wba,
                         input logic [31:0] data, input logic [31:0] addr, input logic [2:0] ff);
        int          a;
        bit          twoWord, pcPop, flPop, plainLoad, checkData;
        logic [15:0] expData;
        logic [31:0] expPc;
        logic [2:0]  expFl;

        a         = int'(addr[10:0]);
        twoWord   = spc && (mr || mw);
        pcPop     = twoWord && !mw;
        flPop     = mr && !mw && sfl && !spc;
        plainLoad = mr && !mw && !spc && !sfl;
        checkData = plainLoad || !(mr || mw) || (mr && mw && !spc && !sfl);
        expData   = plainLoad ? refMem[a] : data[15:0];
        expPc     = {refMem[(a + 1) % 2048], refMem[a]};
        expFl     = refMem[a][2:0];

        if (mw) begin
            if (spc) begin
                refMem[a]                 = data[31:16];
                refMem[(a + 2047) % 2048] = data[15:0];
            end else if (sfl) begin
                refMem[a] = {13'd0, ff};
            end else begin
                refMem[a] = data[15:0];
            end
        end

        applyStimulus(mr, mw, spc, sfl, jwsp, wb, wba, data, addr, ff);
        #1;
        checkOutput({tag, ".stall"}, 32'(Stall), 32'(twoWord));
        if (twoWord) begin
            nextCycle();
            checkOutput({tag, ".stall2"}, 32'(Stall), 32'd0);
            checkOutput({tag, ".sp_extra"}, 32'(SP_Extra), 32'd1);
            checkOutput({tag, ".sp_inc"}, 32'(SP_Extra_Inc), 32'(!mw));
            checkOutput({tag, ".bubble"}, 32'(WB_Out), 32'd0);
        end
        nextCycle();
        checkOutput({tag, ".wb_out"}, 32'(WB_Out), 32'(wb));
        checkOutput({tag, ".wb_addr"}, 32'(WB_Address_Out), 32'(wba));
        checkOutput({tag, ".pc_load"}, 32'(PC_Load), 32'(pcPop && jwsp));
        checkOutput({tag, ".flags_load"}, 32'(Flags_Load), 32'(flPop));
        if (checkData) checkOutput({tag, ".wb_data"}, 32'(WB_Data), 32'(expData));
        if (flPop) checkOutput({tag, ".flags_out"}, 32'(Flags_Out), 32'(expFl));
        if (pcPop) checkOutput({tag, ".pc_out"}, PC_Out, expPc);
        applyNop();
    endtask

    task automatic doStore(input string tag, input logic [31:0] addr, input logic [15:0] value);
        runOp(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, {16'd0, value}, addr, 3'd0);
    endtask

    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] wba);
        runOp(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wba, 32'd0, addr, 3'd0);
    endtask

    initial begin
        int          kind;
        int          off;
        logic [31:0] addr;

        rst = 1'b1;
        applyNop();
        repeat (3) nextCycle();
        checkAllZero("reset");
        rst = 1'b0;

        doStore("store10", 32'h10, 16'hABCD);
        doLoad("load10", 32'h10, 3'd3);
        checkOutput("load10.value", 32'(WB_Data), 32'h0000ABCD);

        runOp("pcpush", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00120345, 32'h7FF, 3'd0);
        runOp("pcpop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'h7FE, 3'd0);
        checkOutput("pcpop.value", PC_Out, 32'h00120345);
        nextCycle();
        checkOutput("pcpop.pulse_end", 32'(PC_Load), 32'd0);
        checkOutput("pcpop.hold", PC_Out, 32'h00120345);
        doLoad("peek7ff", 32'h7FF, 3'd1);
        checkOutput("peek7ff.value", 32'(WB_Data), 32'h0012);

        runOp("flpush", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'h50, 3'b101);
        runOp("flpop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'h50, 3'd0);
        checkOutput("flpop.value", 32'(Flags_Out), 32'b101);
        nextCycle();
        checkOutput("flpop.pulse_end", 32'(Flags_Load), 32'd0);
        doLoad("peek50", 32'h50, 3'd2);
        checkOutput("peek50.value", 32'(WB_Data), 32'h0005);

        runOp("conflict", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 32'h00001111, 32'h00010003, 3'd0);
        checkOutput("conflict.value", 32'(WB_Data), 32'h1111);
        doLoad("peek003", 32'h3, 3'd4);

        doStore("wraphi", 32'h000, 16'h3333);
        doStore("wraplo", 32'h7FF, 16'h2222);
        runOp("wrappop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 32'h00000077, 32'h7FF, 3'd0);
        checkOutput("wrappop.value", PC_Out, 32'h33332222);

        doStore("pre1f", 32'h1F, 16'hBEEF);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hAAAA5555, 32'h20, 3'd0);
        #1;
        checkOutput("rstmid.stall", 32'(Stall), 32'd1);
        nextCycle();
        refMem[32'h20] = 16'hAAAA;
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyNop();
        #1;
        checkAllZero("rstmid");
        doLoad("rstmid.keep1f", 32'h1F, 3'd0);
        doLoad("rstmid.first20", 32'h20, 3'd7);

        for (int i = 0; i < 16; i++) begin
            doStore("fill", 32'((32'h7F8 + i) & 32'h7FF), 16'($urandom));
        end

        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 7));
            off  = int'($urandom_range(1, 14));
            addr = {$urandom_range(0, 3) == 0 ? 21'($urandom) : 21'd0, 11'((11'h7F8 + 11'(off)))};
            case (kind)
                0: runOp("rnd.store", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 3'($urandom), $urandom, addr, 3'd0);
                1: runOp("rnd.load", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'($urandom), $urandom, addr, 3'd0);
                2: runOp("rnd.flpush", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, $urandom, addr, 3'($urandom));
                3: runOp("rnd.flpop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, $urandom, addr, 3'd0);
                4: runOp("rnd.pcpush", 1'b0, 1'b1, 1'b1, 1'($urandom), 1'b0, 1'($urandom), 3'($urandom), $urandom, addr, 3'($urandom));
                5: runOp("rnd.pcpop", 1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, addr, 3'd0);
                6: runOp("rnd.nop", 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 3'($urandom), $urandom, $urandom, 3'd0);
                default: runOp("rnd.conflict", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'($urandom), $urandom, addr, 3'd0);
            endcase
        end

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execution unit; consumes the EX/MEM buffer fields.
- Owns the 16-bit-wide data/stack memory and performs loads, stores, flag push/pop and two-word PC push/pop.
- Pop of PC is used by RET/RTI; push of PC is used by CALL/INT.
- Produces the registered MEM/WB fields for write-back, plus PC-load and flag-restore pulses.
- Two-word PC accesses stall the upstream pipeline for one cycle.

Parameters:
ADDR_WIDTH, 11, word-address width of data memory (depth 2**ADDR_WIDTH words, 16 bits each)
DATA_WIDTH, 16, memory word width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
Data  input  32  EX result; [15:0] store/WB data, full 32 bits = PC for push
Address  input  32  EX address; only [ADDR_WIDTH-1:0] used
WB_Address  input  3  destination register
MR  input  1  memory read
MW  input  1  memory write
WB  input  1  register write-back enable
JWSP  input  1  jump-with-stack op (PC comes from memory on pop)
Stack_PC  input  1  access is a 32-bit PC push/pop
Stack_Flags  input  1  access is a flags push/pop
Final_Flags  input  3  NF|CF|ZF from EX
Stall  output  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM for one cycle
SP_Extra  output  1  one-cycle pulse: stack pointer takes one extra step
SP_Extra_Inc  output  1  with SP_Extra: 1 = +1 (pop), 0 = -1 (push)
WB_Out  output  1  registered write-back enable
WB_Address_Out  output  3  registered destination register
WB_Data  output  16  registered write-back data
Flags_Load  output  1  registered pulse: restore flags from Flags_Out
Flags_Out  output  3  registered popped flags
PC_Load  output  1  registered pulse: load PC_Out into PC
PC_Out  output  32  registered popped PC

Behaviour:
- Reset: state IDLE; all outputs 0. Memory contents are not reset. A reset during SECOND aborts the op and suppresses the second access.
- Index A = Address[ADDR_WIDTH-1:0]. Address±1 wraps modulo depth.
- Memory read is synchronous (one-cycle): results register on the same edge as the access.
- FSM states:
  - IDLE: two-word op = Stack_PC & (MR|MW). If present: Stall=1, perform first access, go to SECOND. Else perform single access, stay in IDLE.
  - SECOND: Stall=0 (inputs still held stable by the frozen upstream). Perform second access, pulse SP_Extra for the cycle, return to IDLE.
- PC push (MW & Stack_PC):
  - IDLE: mem[A] <= Data[31:16].
  - SECOND: mem[A-1] <= Data[15:0]; SP_Extra=1, SP_Extra_Inc=0.
- PC pop (MR & Stack_PC):
  - IDLE: read mem[A] into PC_Out[15:0].
  - SECOND: read mem[A+1] into PC_Out[31:16]; SP_Extra=1, SP_Extra_Inc=1. PC_Load=1 on exit from SECOND if JWSP=1.
- Flags push (MW & Stack_Flags): mem[A] <= {13'b0, Final_Flags}.
- Flags pop (MR & Stack_Flags): Flags_Out <= mem[A][2:0]; Flags_Load=1 next cycle.
- Plain store (MW, no stack bit): mem[A] <= Data[15:0].
- Plain load (MR, no stack bit): WB_Data <= mem[A].
- Non-memory op: WB_Data <= Data[15:0].
- MR & MW both set: write performed, read suppressed, WB_Data <= Data[15:0].
- Stack_PC & Stack_Flags both set: Stack_PC wins.
- MEM/WB timing:
  - Single-word ops: outputs update on the edge after sampling (latency 1).
  - Two-word ops: the IDLE (stall) cycle emits a bubble (WB_Out=0, PC_Load=0, Flags_Load=0). Real outputs appear at the end of SECOND (latency 2).
- Pulses (Flags_Load, PC_Load, SP_Extra) last exactly one cycle.
- Back-to-back two-word ops: SECOND returns to IDLE, which re-evaluates and may stall again immediately.

Decomposition:
- Shared package mem_stage_pkg:
  - state enum {IDLE, SECOND}
  - ADDR_WIDTH, DATA_WIDTH defaults
  - flag bit index constants ZF=0, CF=1, NF=2
- Sub-module data_memory: single-port synchronous RAM, DATA_WIDTH x 2**ADDR_WIDTH, one write enable, registered read. Also used by verification for backdoor preload.

Test Plan:
- Store/load: MW, Address=0x10, Data=0x0000ABCD; then MR, WB=1, WB_Address=3, Address=0x10 -> one cycle later WB_Out=1, WB_Address_Out=3, WB_Data=0xABCD, Stall never set.
- PC push: MW, Stack_PC, Address=0x7FF, Data=0x00120345 -> Stall=1 for one cycle; mem[0x7FF]=0x0012, mem[0x7FE]=0x0345; SP_Extra=1 with SP_Extra_Inc=0 in SECOND; bubble (WB_Out=0) in first cycle.
- PC pop/RET: preloaded as above, MR, Stack_PC, JWSP, Address=0x7FE -> Stall one cycle, then PC_Load=1 for exactly one cycle with PC_Out=0x00120345; SP_Extra_Inc=1.
- Flags round trip: MW, Stack_Flags, Final_Flags=3'b101, Address=0x50; then MR, Stack_Flags, Address=0x50 -> Flags_Load=1, Flags_Out=3'b101, mem[0x50]=0x0005.
- Reset mid-op: start PC push at Address=0x20, assert rst in SECOND -> mem[0x1F] unchanged, state IDLE, all outputs 0 next cycle.
- Wrap/conflict: MR & MW, Address=0x0001_0003, Data=0x1111 -> mem[0x003]=0x1111 (upper bits ignored), WB_Data=0x1111; PC pop at Address=0x7FF reads high word from 0x000.
